hazard_forward_unit: RTL

Parametrised successor to the pipeline forwarding logic. It keeps its own shadow of the destination registers in flight across NUM_STAGES post-decode stages. From that shadow it produces nearest-stage forwarding selects for both ID-stage source operands. It also generates load-use stalls, multi-cycle multiply stalls with an EX hold, and branch-flush bubbles. It sits beside the ID/EX pipeline register and drives the operand forwarding muxes and the PC/IF/ID/EX enables.

---
 rtl/hazard_forward_unit_pkg.sv | 25 ++
 rtl/hazard_forward_unit_fwd_select.sv | 51 +++++
 rtl/hazard_forward_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// rtl/hazard_forward_unit_pkg.sv - shared types and constants for the hazard/forwarding unit
//
// Purpose: shadow-entry struct and default constants shared by the top and fwd_select.
// Contents:
//   REG_BITS_DEFAULT  default register address width
//   ZERO_REG_DEFAULT  default hardwired-zero register
//   MAX_REG_BITS      storage width of dest in a shadow entry (REG_BITS must not exceed it)
//   FWD_RF            select value meaning "read the register file"
//   shadowEntry_t     valid, regWrite, dest, isLoad
package hazard_forward_unit_pkg;

  localparam int REG_BITS_DEFAULT = 5;
  localparam int ZERO_REG_DEFAULT = 31;
  localparam int MAX_REG_BITS     = 8;
  localparam int FWD_RF           = 0;

  // dest is stored zero-extended so one struct serves every REG_BITS setting.
  typedef struct packed {
    logic                    valid;
    logic                    regWrite;
    logic [MAX_REG_BITS-1:0] dest;
    logic                    isLoad;
  } shadowEntry_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// rtl/hazard_forward_unit_fwd_select.sv - nearest-stage forwarding select for one source operand
//
// Purpose: priority match of one source address across the shadow array.
// Ports:
//   shadow   in   per-stage shadow entries, index k = stage k (1 = EX)
//   addr     in   ID-stage source register address
//   sel      out  0 = register file, k = forward from stage k
//   loadHit  out  nearest producer is a load still in stage 1 (not forwardable)
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int REG_BITS   = REG_BITS_DEFAULT,
  parameter int ZERO_REG   = ZERO_REG_DEFAULT,
  parameter int SEL_BITS   = $clog2(NUM_STAGES + 1)
) (
  input  shadowEntry_t [NUM_STAGES:1] shadow,
  input  logic [REG_BITS-1:0]         addr,
  output logic [SEL_BITS-1:0]         sel,
  output logic                        loadHit
);

  logic [MAX_REG_BITS-1:0] addrExt;
  logic                    addrIsZero;
  logic                    found;
  shadowEntry_t            entry;

  assign addrExt    = MAX_REG_BITS'(addr);
  assign addrIsZero = (addr == REG_BITS'(ZERO_REG));

  always_comb begin
    sel     = SEL_BITS'(FWD_RF);
    loadHit = 1'b0;
    found   = 1'b0;
    entry   = '0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      entry = shadow[k];
      if (!found && !addrIsZero && entry.valid && entry.regWrite && entry.dest == addrExt) begin
        found = 1'b1;
        // A load still in EX has no data yet: the nearest producer wins, so
        // nothing older may be forwarded; the operand stalls instead.
        if (k == 1 && entry.isLoad) begin
          loadHit = 1'b1;
        end else begin
          sel = SEL_BITS'(k);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - shadow-tracked forwarding selects, load-use/multiply stalls, flush
//
// Purpose: tracks destinations of instructions in the NUM_STAGES post-decode stages and
// drives operand forwarding selects and pipeline enables.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   Aa, Ab, use_Aa, use_Ab       ID source addresses and read enables
//   id_valid, id_regwrite,
//   id_dest, id_is_load,
//   id_is_mul                    ID instruction fields
//   flush                        branch taken: kill EX and ID
//   forwardA, forwardB           0 = register file, k = forward from stage k
//   stall                        hold PC, IF/ID and ID
//   ex_hold                      hold ID/EX (multiply busy)
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int REG_BITS    = REG_BITS_DEFAULT,
  parameter int ZERO_REG    = ZERO_REG_DEFAULT,
  parameter int MUL_LATENCY = 3,
  localparam int SEL_BITS   = $clog2(NUM_STAGES + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [REG_BITS-1:0] Aa,
  input  logic [REG_BITS-1:0] Ab,
  input  logic                use_Aa,
  input  logic                use_Ab,
  input  logic                id_valid,
  input  logic                id_regwrite,
  input  logic [REG_BITS-1:0] id_dest,
  input  logic                id_is_load,
  input  logic                id_is_mul,
  input  logic                flush,
  output logic [SEL_BITS-1:0] forwardA,
  output logic [SEL_BITS-1:0] forwardB,
  output logic                stall,
  output logic                ex_hold
);

  localparam int CNT_BITS = $clog2(MUL_LATENCY + 1);

  shadowEntry_t [NUM_STAGES:1] shadow;
  shadowEntry_t [NUM_STAGES:1] shadowNext;
  logic [CNT_BITS-1:0]         mulCnt;
  logic [CNT_BITS-1:0]         mulCntNext;
  shadowEntry_t                idEntry;
  logic                        loadHitA;
  logic                        loadHitB;
  logic                        loadUse;
  logic                        mulBusy;

  fwd_select #(
    .NUM_STAGES(NUM_STAGES),
    .REG_BITS  (REG_BITS),
    .ZERO_REG  (ZERO_REG),
    .SEL_BITS  (SEL_BITS)
  ) selA (
    .shadow (shadow),
    .addr   (Aa),
    .sel    (forwardA),
    .loadHit(loadHitA)
  );

  fwd_select #(
    .NUM_STAGES(NUM_STAGES),
    .REG_BITS  (REG_BITS),
    .ZERO_REG  (ZERO_REG),
    .SEL_BITS  (SEL_BITS)
  ) selB (
    .shadow (shadow),
    .addr   (Ab),
    .sel    (forwardB),
    .loadHit(loadHitB)
  );

  assign mulBusy = (mulCnt != '0);
  assign loadUse = (loadHitA & use_Aa) | (loadHitB & use_Ab);
  assign stall   = ~flush & (loadUse | mulBusy);
  assign ex_hold = ~flush & mulBusy;

  always_comb begin
    idEntry          = '0;
    idEntry.valid    = id_valid;
    idEntry.regWrite = id_regwrite;
    idEntry.dest     = MAX_REG_BITS'(id_dest);
    idEntry.isLoad   = id_is_load;
  end

  always_comb begin
    shadowNext = shadow;
    mulCntNext = mulCnt;
    for (int k = 2; k <= NUM_STAGES; k++) begin
      shadowNext[k] = shadow[k-1];
    end
    if (flush) begin
      // The killed EX entry must not reappear in MEM, so it is dropped
      // before the shift and no ID entry replaces it.
      shadowNext[1] = '0;
      shadowNext[2] = '0;
      mulCntNext    = '0;
    end else if (mulBusy) begin
      // Multiply stays in EX; the slot behind it drains as a bubble.
      shadowNext[1] = shadow[1];
      shadowNext[2] = '0;
      mulCntNext    = mulCnt - CNT_BITS'(1);
    end else if (loadUse) begin
      shadowNext[1] = '0;
    end else begin
      shadowNext[1] = idEntry;
      if (id_valid && id_is_mul) begin
        mulCntNext = CNT_BITS'(MUL_LATENCY - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      mulCnt <= '0;
    end else begin
      shadow <= shadowNext;
      mulCnt <= mulCntNext;
    end
  end

endmodule
